pe_feeder: RTL and testbench

Upstream stage of the systolic PE. It buffers incoming weight/activation pairs in a circular FIFO. On command it streams a burst of LEN pairs to a PE's w/a/fire inputs, driving fire high for exactly LEN consecutive cycles and then deasserting it. This gives the PE its uninterrupted fire window and marks the end of the accumulation run with a done pulse.

---
 rtl/pe_feeder.sv | 136 +++++++++++++
 tb/tb_pe_feeder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_feeder.sv
// Operand feeder for a systolic PE: buffers weight/activation pairs in a circular
// FIFO and streams a gap-free burst of LEN pairs on command, ending with a done pulse.
module pe_feeder #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned LW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_w,
    input  logic [DW-1:0] in_a,
    input  logic          start,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          fire,
    output logic [DW-1:0] w,
    output logic [DW-1:0] a,
    output logic [LW-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_STREAM,
        ST_END
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [LW-1:0]   count_q;
    logic [LW-1:0]   count_d;
    logic [LW-1:0]   rem_q;
    logic            fire_q;
    logic            done_q;
    logic            busy_q;
    logic [DW-1:0]   w_q;
    logic [DW-1:0]   a_q;
    logic [DW-1:0]   mem_w_q [DEPTH];
    logic [DW-1:0]   mem_a_q [DEPTH];

    logic            push;
    logic            pop;
    logic            start_ok;

    // Full check looks only at registered occupancy, never at a same-cycle pop.
    assign in_ready = (count_q < LW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state_q == ST_STREAM);
    assign start_ok = start && (len != '0) && (len <= LW'(DEPTH));

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + LW'(1);
        end else if (!push && pop) begin
            count_d = count_q - LW'(1);
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_w_q[wr_ptr_q] <= in_w;
            mem_a_q[wr_ptr_q] <= in_a;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rem_q    <= '0;
            fire_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            w_q      <= '0;
            a_q      <= '0;
        end else begin
            count_q <= count_d;
            done_q  <= 1'b0;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    // busy stays up through the done cycle, then drops here
                    busy_q <= 1'b0;
                    if (start_ok) begin
                        rem_q   <= len;
                        busy_q  <= 1'b1;
                        state_q <= (count_q >= len) ? ST_STREAM : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (count_q >= rem_q) begin
                        state_q <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    w_q      <= mem_w_q[rd_ptr_q];
                    a_q      <= mem_a_q[rd_ptr_q];
                    fire_q   <= 1'b1;
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                    rem_q    <= rem_q - LW'(1);
                    if (rem_q == LW'(1)) begin
                        state_q <= ST_END;
                    end
                end
                ST_END: begin
                    fire_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign fire  = fire_q;
    assign w     = w_q;
    assign a     = a_q;
    assign count = count_q;

endmodule

// File: tb/tb_pe_feeder.sv
// Randomized scoreboard bench for pe_feeder: accepted writes form the expected
// stream, a negedge monitor checks every fire beat, burst length, done and occupancy.
module tb_pe_feeder;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LW    = 5;

    typedef struct {
        logic [DW-1:0] w;
        logic [DW-1:0] a;
    } pair_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_w;
    logic [DW-1:0] in_a;
    logic          start;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          fire;
    logic [DW-1:0] w;
    logic [DW-1:0] a;
    logic [LW-1:0] count;

    pe_feeder #(.DW(DW), .DEPTH(DEPTH), .LW(LW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_w     (in_w),
        .in_a     (in_a),
        .start    (start),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .fire     (fire),
        .w        (w),
        .a        (a),
        .count    (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: FIFO contents in acceptance order, and the lengths of accepted bursts.
    pair_t exp_q[$];
    int    burst_q[$];
    bit    model_busy;
    int    tests;
    int    fails;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: pops the model on every fire beat and checks per-cycle invariants.
    logic          prev_fire;
    int            run_len;
    logic [DW-1:0] last_w;
    logic [DW-1:0] last_a;
    pair_t         p;

    always @(negedge clk) begin
        if (rst) begin
            prev_fire = 1'b0;
            run_len   = 0;
            last_w    = '0;
            last_a    = '0;
        end else begin
            if (fire) begin
                if (exp_q.size() == 0) begin
                    flag("fire_without_data");
                end else begin
                    p = exp_q.pop_front();
                    check("w_out", 32'(w), 32'(p.w));
                    check("a_out", 32'(a), 32'(p.a));
                end
                last_w = w;
                last_a = a;
                run_len++;
            end else begin
                check("w_hold", 32'(w), 32'(last_w));
                check("a_hold", 32'(a), 32'(last_a));
                if (prev_fire) begin
                    if (burst_q.size() == 0) begin
                        flag("burst_unexpected");
                    end else begin
                        check("burst_len", 32'(run_len), 32'(burst_q.pop_front()));
                    end
                    run_len = 0;
                end
            end
            check("done_pulse", 32'(done), 32'(prev_fire && !fire));
            check("count", 32'(count), 32'(exp_q.size()));
            check("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
            prev_fire = fire;
        end
    end

    // All stimulus tasks start and end one time unit after a rising edge.
    task automatic write(input logic [DW-1:0] wv, input logic [DW-1:0] av);
        in_valid = 1'b1;
        in_w     = wv;
        in_a     = av;
        @(posedge clk);
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back('{w: wv, a: av});
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_start(input int l);
        bit legal;
        legal = !model_busy && (l >= 1) && (l <= DEPTH);
        start = 1'b1;
        len   = LW'(l);
        @(posedge clk);
        if (legal) begin
            burst_q.push_back(l);
            model_busy = 1'b1;
        end
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            flag("done_timeout");
        end else begin
            check("busy_at_done", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1;
        check("busy_after_done", 32'(busy), 32'd0);
        model_busy = 1'b0;
    endtask

    task automatic check_quiet(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("quiet_fire", 32'(fire), 32'd0);
            check("quiet_busy", 32'(busy), 32'd0);
            check("quiet_done", 32'(done), 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_fire", 32'(fire), 32'd0);
        check("rst_w", 32'(w), 32'd0);
        check("rst_a", 32'(a), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        exp_q.delete();
        burst_q.delete();
        model_busy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc;
        int n;
        int l;
        tests      = 0;
        fails      = 0;
        model_busy = 1'b0;
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_w       = '0;
        in_a       = '0;
        start      = 1'b0;
        len        = '0;

        // Reset asserted between edges
        #2;
        do_reset();

        // Basic full burst; the 17th write is refused
        for (int i = 1; i <= 16; i++) write(DW'(i), DW'(1));
        write(8'hAA, 8'h55);
        do_start(16);
        wait_done(40);

        // Pointer-wrap setup burst
        for (int i = 0; i < 12; i++) write(DW'($urandom), DW'($urandom));
        do_start(12);
        wait_done(40);

        // Wait path: start with too few entries, then top up
        for (int i = 0; i < 3; i++) write(DW'($urandom), DW'($urandom));
        do_start(5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wait_fire", 32'(fire), 32'd0);
            check("wait_busy", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) write(DW'($urandom), DW'($urandom));
        wait_done(30);

        // Concurrent load while streaming across the wrapped pointers
        for (int i = 0; i < 10; i++) write(DW'($urandom), DW'($urandom));
        do_start(10);
        for (int i = 0; i < 6; i++) write(DW'($urandom), DW'($urandom));
        wait_done(40);
        check("leftover_count", 32'(count), 32'd6);
        do_start(6);
        wait_done(30);

        // Illegal starts
        for (int i = 0; i < 4; i++) write(DW'($urandom), DW'($urandom));
        do_start(0);
        check_quiet(3);
        do_start(17);
        check_quiet(3);
        do_start(4);
        do_start(2);
        wait_done(30);
        check_quiet(4);

        // Reset on the 4th fire cycle of an 8-long burst
        for (int i = 0; i < 8; i++) write(DW'($urandom), DW'($urandom));
        do_start(8);
        fc = 0;
        for (int i = 0; i < 20 && fc < 4; i++) begin
            @(negedge clk);
            if (fire) fc++;
        end
        if (fc < 4) flag("fire_timeout");
        #2;
        do_reset();
        check_quiet(3);
        for (int i = 0; i < 5; i++) write(DW'($urandom), DW'($urandom));
        do_start(5);
        wait_done(30);

        // Random bursts with carry-over between them
        for (int k = 0; k < 8; k++) begin
            if (exp_q.size() < DEPTH) begin
                n = $urandom_range(DEPTH - exp_q.size(), 1);
                for (int i = 0; i < n; i++) write(DW'($urandom), DW'($urandom));
            end
            l = $urandom_range(exp_q.size(), 1);
            do_start(l);
            wait_done(60);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
